// File: rtl/axi4_arb_pkg.sv
// Shared types for the two-master AXI4-subset arbiter: per-path FSM states
// and the master count.
package axi4_arb_pkg;

  localparam int NM = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  function automatic logic [NM-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi4_rr_arbiter_2to1_rr_pick2.sv
// Two-way round-robin picker: remembers the last master served and prefers
// the other one whenever both request.
module rr_pick2
  import axi4_arb_pkg::*;
(
  input  logic          clk,
  input  logic          _rst,
  input  logic [NM-1:0] i_req,
  input  logic          i_update,
  input  logic          i_upd_idx,
  output logic          o_gnt_idx
);

  logic r_last;

  // Starts as "master 1 served last" so master 0 wins the first contest.
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= i_upd_idx;
    end
  end

  assign o_gnt_idx = i_req[~r_last] ? ~r_last : r_last;

endmodule

// File: rtl/axi4_rr_arbiter_2to1.sv
// Two-master to one-slave AXI4-subset arbiter. Write (AW/W/B) and read (AR/R)
// paths are arbitrated independently; a grant covers one whole transaction.
module axi4_rr_arbiter_2to1
  import axi4_arb_pkg::*;
#(
  parameter int ASZ = 2,
  parameter int DSZ = 8
) (
  input  logic             clk,
  input  logic             _rst,
  // master side, write
  input  logic [2*ASZ-1:0] m_awaddr,
  input  logic [1:0]       m_awvalid,
  output logic [1:0]       m_awready,
  input  logic [2*DSZ-1:0] m_wdata,
  input  logic [1:0]       m_wvalid,
  input  logic [1:0]       m_wlast,
  output logic [1:0]       m_wready,
  output logic [1:0]       m_bresp,
  output logic [1:0]       m_bvalid,
  input  logic [1:0]       m_bready,
  // master side, read
  input  logic [2*ASZ-1:0] m_araddr,
  input  logic [1:0]       m_arvalid,
  output logic [1:0]       m_arready,
  output logic [DSZ-1:0]   m_rdata,
  output logic             m_rlast,
  output logic             m_rresp,
  output logic [1:0]       m_rvalid,
  input  logic [1:0]       m_rready,
  // slave side, write
  output logic [ASZ-1:0]   s_awaddr,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [DSZ-1:0]   s_wdata,
  output logic             s_wvalid,
  output logic             s_wlast,
  input  logic             s_wready,
  input  logic             s_bresp,
  input  logic             s_bvalid,
  output logic             s_bready,
  // slave side, read
  output logic [ASZ-1:0]   s_araddr,
  output logic             s_arvalid,
  input  logic             s_arready,
  input  logic [DSZ-1:0]   s_rdata,
  input  logic             s_rvalid,
  input  logic             s_rlast,
  input  logic             s_rresp,
  output logic             s_rready,
  // ownership
  output logic [1:0]       wr_gnt,
  output logic [1:0]       rd_gnt
);

  // ---------------------------------------------------------------- write path
  wr_state_t r_wr_state;
  logic      r_wr_g;
  logic [1:0] r_wr_gnt;
  logic      w_wr_pick;
  logic      w_wr_done;

  logic [ASZ-1:0] w_awaddr_g;
  logic [DSZ-1:0] w_wdata_g;

  assign w_wr_done  = (r_wr_state == W_RESP) && s_bvalid && s_bready;
  assign w_awaddr_g = r_wr_g ? m_awaddr[ASZ +: ASZ] : m_awaddr[0 +: ASZ];
  assign w_wdata_g  = r_wr_g ? m_wdata[DSZ +: DSZ]  : m_wdata[0 +: DSZ];

  rr_pick2 u_wr_pick (
    .clk       (clk),
    ._rst      (_rst),
    .i_req     (m_awvalid),
    .i_update  (w_wr_done),
    .i_upd_idx (r_wr_g),
    .o_gnt_idx (w_wr_pick)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_wr_state <= W_IDLE;
      r_wr_g     <= 1'b0;
      r_wr_gnt   <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (|m_awvalid) begin
          r_wr_g     <= w_wr_pick;
          r_wr_gnt   <= onehot2(w_wr_pick);
          r_wr_state <= W_ADDR;
        end
        W_ADDR: if (s_awvalid && s_awready) r_wr_state <= W_DATA;
        W_DATA: if (s_wvalid && s_wready && s_wlast) r_wr_state <= W_RESP;
        W_RESP: if (w_wr_done) begin
          r_wr_gnt   <= '0;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Zero-latency routing between the owner and the slave; only the channel
  // of the current state is open, everything else reads as 0.
  // NOTE: every output gets a default before the case so no latch is
  // inferred for states that leave a signal untouched.
  always_comb begin
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    case (r_wr_state)
      W_ADDR: begin
        s_awaddr  = w_awaddr_g;
        s_awvalid = m_awvalid[r_wr_g];
        m_awready = r_wr_gnt & {2{s_awready}};
      end
      W_DATA: begin
        s_wdata  = w_wdata_g;
        s_wvalid = m_wvalid[r_wr_g];
        s_wlast  = m_wlast[r_wr_g];
        m_wready = r_wr_gnt & {2{s_wready}};
      end
      W_RESP: begin
        s_bready = m_bready[r_wr_g];
        m_bvalid = r_wr_gnt & {2{s_bvalid}};
        m_bresp  = r_wr_gnt & {2{s_bresp}};
      end
      default: ;
    endcase
  end

  assign wr_gnt = r_wr_gnt;

  // ----------------------------------------------------------------- read path
  rd_state_t r_rd_state;
  logic      r_rd_g;
  logic [1:0] r_rd_gnt;
  logic      w_rd_pick;
  logic      w_rd_done;

  logic [ASZ-1:0] w_araddr_g;

  assign w_rd_done  = (r_rd_state == R_DATA) && s_rvalid && s_rready && s_rlast;
  assign w_araddr_g = r_rd_g ? m_araddr[ASZ +: ASZ] : m_araddr[0 +: ASZ];

  rr_pick2 u_rd_pick (
    .clk       (clk),
    ._rst      (_rst),
    .i_req     (m_arvalid),
    .i_update  (w_rd_done),
    .i_upd_idx (r_rd_g),
    .o_gnt_idx (w_rd_pick)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_rd_state <= R_IDLE;
      r_rd_g     <= 1'b0;
      r_rd_gnt   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (|m_arvalid) begin
          r_rd_g     <= w_rd_pick;
          r_rd_gnt   <= onehot2(w_rd_pick);
          r_rd_state <= R_ADDR;
        end
        R_ADDR: if (s_arvalid && s_arready) r_rd_state <= R_DATA;
        R_DATA: if (w_rd_done) begin
          r_rd_gnt   <= '0;
          r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Read data, last and resp are broadcast; only rvalid is steered.
  always_comb begin
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    m_rresp   = 1'b0;
    case (r_rd_state)
      R_ADDR: begin
        s_araddr  = w_araddr_g;
        s_arvalid = m_arvalid[r_rd_g];
        m_arready = r_rd_gnt & {2{s_arready}};
      end
      R_DATA: begin
        s_rready = m_rready[r_rd_g];
        m_rvalid = r_rd_gnt & {2{s_rvalid}};
        m_rdata  = s_rdata;
        m_rlast  = s_rlast;
        m_rresp  = s_rresp;
      end
      default: ;
    endcase
  end

  assign rd_gnt = r_rd_gnt;

endmodule

// File: tb/tb_axi4_rr_arbiter_2to1.sv
// Bench for axi4_rr_arbiter_2to1: directed master traffic, a small slave model,
// and a scoreboard monitor checking every handshake against queued expectations.
module tb_axi4_rr_arbiter_2to1;

  localparam int ASZ = 2;
  localparam int DSZ = 8;

  logic clk  = 1'b0;
  logic _rst = 1'b0;
  always #5 clk = ~clk;

  // per-master drive variables
  logic [ASZ-1:0] tb_awaddr[2];
  logic           tb_awv[2];
  logic [DSZ-1:0] tb_wdata[2];
  logic           tb_wv[2];
  logic           tb_wlast[2];
  logic           tb_bready[2];
  logic [ASZ-1:0] tb_araddr[2];
  logic           tb_arv[2];
  logic           tb_rready[2];

  logic [2*ASZ-1:0] m_awaddr, m_araddr;
  logic [2*DSZ-1:0] m_wdata;
  logic [1:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [1:0] m_bresp, m_bvalid, m_bready, m_arvalid, m_arready;
  logic [1:0] m_rvalid, m_rready, wr_gnt, rd_gnt;
  logic [DSZ-1:0] m_rdata, s_wdata, s_rdata;
  logic m_rlast, m_rresp;
  logic [ASZ-1:0] s_awaddr, s_araddr;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bresp, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rresp, s_rready;

  assign m_awaddr  = {tb_awaddr[1], tb_awaddr[0]};
  assign m_awvalid = {tb_awv[1], tb_awv[0]};
  assign m_wdata   = {tb_wdata[1], tb_wdata[0]};
  assign m_wvalid  = {tb_wv[1], tb_wv[0]};
  assign m_wlast   = {tb_wlast[1], tb_wlast[0]};
  assign m_bready  = {tb_bready[1], tb_bready[0]};
  assign m_araddr  = {tb_araddr[1], tb_araddr[0]};
  assign m_arvalid = {tb_arv[1], tb_arv[0]};
  assign m_rready  = {tb_rready[1], tb_rready[0]};

  // slave model: B one cycle after wlast; 8 read beats of 0x80 + addr*16 + k
  logic       sl_awready = 1'b1;
  logic       sl_wready  = 1'b1;
  logic       sl_arready = 1'b1;
  logic       sl_bpend;
  logic [3:0] sl_rcnt;
  logic [7:0] sl_rbase;

  assign s_awready = sl_awready;
  assign s_wready  = sl_wready;
  assign s_arready = sl_arready;
  assign s_bvalid  = sl_bpend;
  assign s_bresp   = 1'b1;
  assign s_rvalid  = (sl_rcnt != 4'd0);
  assign s_rdata   = sl_rbase + {4'h0, 4'd8 - sl_rcnt};
  assign s_rlast   = (sl_rcnt == 4'd1);
  assign s_rresp   = 1'b1;

  always @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sl_bpend <= 1'b0;
      sl_rcnt  <= 4'd0;
      sl_rbase <= 8'h00;
    end else begin
      if (s_wvalid && s_wready && s_wlast) sl_bpend <= 1'b1;
      else if (s_bvalid && s_bready)      sl_bpend <= 1'b0;
      if (s_arvalid && s_arready) begin
        sl_rcnt  <= 4'd8;
        sl_rbase <= 8'h80 + {2'b00, s_araddr, 4'h0};
      end else if (s_rvalid && s_rready) begin
        sl_rcnt <= sl_rcnt - 4'd1;
      end
    end
  end

  axi4_rr_arbiter_2to1 #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), ._rst(_rst),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rresp(s_rresp),
    .s_rready(s_rready),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int         m;
    logic [7:0] v;
    logic       last;
  } exp_t;

  exp_t q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];
  int n_tests = 0;
  int n_fail  = 0;
  int aw_cnt[2] = '{0, 0};
  int b_cnt[2]  = '{0, 0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_write(input int m, input logic [1:0] a, input logic [31:0] d);
    q_aw.push_back('{m, 8'(a), 1'b0});
    for (int k = 0; k < 4; k++) q_w.push_back('{m, d[31-8*k -: 8], (k == 3)});
    q_b.push_back('{m, 8'h01, 1'b0});
  endtask

  task automatic push_read(input int m, input logic [1:0] a);
    q_ar.push_back('{m, 8'(a), 1'b0});
    for (int k = 0; k < 8; k++) q_r.push_back('{m, 8'h80 + 8'(a) * 8'd16 + 8'(k), (k == 7)});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (_rst) begin
        if (s_awvalid && s_awready) begin
          check("aw_expected", 32'(q_aw.size() != 0), 1);
          aw_cnt[wr_gnt[1]]++;
          if (q_aw.size() != 0) begin
            e = q_aw.pop_front();
            check("aw_addr", s_awaddr, e.v);
            check("aw_gnt", wr_gnt, 1 << e.m);
          end
        end
        if (s_wvalid && s_wready) begin
          check("w_expected", 32'(q_w.size() != 0), 1);
          if (q_w.size() != 0) begin
            e = q_w.pop_front();
            check("w_data", s_wdata, e.v);
            check("w_last", s_wlast, e.last);
            check("w_gnt", wr_gnt, 1 << e.m);
          end
        end
        if (s_arvalid && s_arready) begin
          check("ar_expected", 32'(q_ar.size() != 0), 1);
          if (q_ar.size() != 0) begin
            e = q_ar.pop_front();
            check("ar_addr", s_araddr, e.v);
            check("ar_gnt", rd_gnt, 1 << e.m);
          end
        end
        for (int m = 0; m < 2; m++) begin
          if (m_bvalid[m] && m_bready[m]) begin
            b_cnt[m]++;
            check("b_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
              e = q_b.pop_front();
              check("b_master", m, e.m);
              check("b_resp", m_bresp[m], e.v);
              check("b_other_quiet", m_bvalid[1-m], 0);
            end
          end
          if (m_rvalid[m] && m_rready[m]) begin
            check("r_expected", 32'(q_r.size() != 0), 1);
            if (q_r.size() != 0) begin
              e = q_r.pop_front();
              check("r_master", m, e.m);
              check("r_data", m_rdata, e.v);
              check("r_last", m_rlast, e.last);
              check("r_resp", m_rresp, 1);
              check("r_other_quiet", m_rvalid[1-m], 0);
            end
          end
        end
      end
    end
  endtask

  // ------------------------------------------------------------ master drivers
  task automatic wait_awready(input int m);
    for (int t = 0; t < 200; t++) begin @(negedge clk); if (m_awready[m]) break; end
    check("awready_seen", m_awready[m], 1);
  endtask

  task automatic wait_wready(input int m);
    for (int t = 0; t < 200; t++) begin @(negedge clk); if (m_wready[m]) break; end
    check("wready_seen", m_wready[m], 1);
  endtask

  task automatic wait_bvalid(input int m);
    for (int t = 0; t < 200; t++) begin @(negedge clk); if (m_bvalid[m]) break; end
    check("bvalid_seen", m_bvalid[m], 1);
  endtask

  task automatic wait_arready(input int m);
    for (int t = 0; t < 200; t++) begin @(negedge clk); if (m_arready[m]) break; end
    check("arready_seen", m_arready[m], 1);
  endtask

  task automatic do_write(input int m, input logic [1:0] a, input logic [31:0] d);
    tb_awaddr[m] = a;
    tb_awv[m]    = 1'b1;
    wait_awready(m);
    @(posedge clk); #1;
    tb_awv[m] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tb_wdata[m] = d[31-8*k -: 8];
      tb_wlast[m] = (k == 3);
      tb_wv[m]    = 1'b1;
      wait_wready(m);
      @(posedge clk); #1;
    end
    tb_wv[m]     = 1'b0;
    tb_wlast[m]  = 1'b0;
    tb_bready[m] = 1'b1;
    wait_bvalid(m);
    @(posedge clk); #1;
    tb_bready[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [1:0] a);
    logic done;
    tb_araddr[m] = a;
    tb_arv[m]    = 1'b1;
    wait_arready(m);
    @(posedge clk); #1;
    tb_arv[m]    = 1'b0;
    tb_rready[m] = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (m_rvalid[m] && m_rlast) done = 1'b1;
    end
    check("rlast_seen", done, 1);
    @(posedge clk); #1;
    tb_rready[m] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},     {wr_gnt, rd_gnt}, 0);
    check({tag, "_m_ready"}, {m_awready, m_wready, m_arready}, 0);
    check({tag, "_m_valid"}, {m_bvalid, m_rvalid, m_rlast, m_rresp, m_bresp}, 0);
    check({tag, "_s_ctl"},   {s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready}, 0);
    check({tag, "_data"},    {s_awaddr, s_araddr, s_wdata, m_rdata}, 0);
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      tb_awaddr[m] = '0; tb_awv[m] = 1'b0; tb_wdata[m] = '0; tb_wv[m] = 1'b0;
      tb_wlast[m] = 1'b0; tb_bready[m] = 1'b0; tb_araddr[m] = '0;
      tb_arv[m] = 1'b0; tb_rready[m] = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------- tests
  initial begin
    int base0, base1;
    clear_masters();
    fork monitor(); join_none

    // reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    _rst = 1'b1;
    @(posedge clk); #1;

    // contested first grant after reset: m0 finishes through B before m1's AW
    push_write(0, 2'd1, 32'h01020304);
    push_write(1, 2'd2, 32'h05060708);
    base0 = b_cnt[0];
    fork
      do_write(0, 2'd1, 32'h01020304);
      do_write(1, 2'd2, 32'h05060708);
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (s_awvalid && wr_gnt == 2'b10) break;
        end
        check("contest_m1_gnt", wr_gnt, 2'b10);
        check("contest_m0_b_first", b_cnt[0], base0 + 1);
      end
    join

    // single m0 write: one cycle of arbitration, AW on the second cycle
    @(posedge clk); #1;
    push_write(0, 2'd0, 32'h11223344);
    fork
      do_write(0, 2'd0, 32'h11223344);
      begin
        @(negedge clk);
        check("lat_arb_awvalid", s_awvalid, 0);
        check("lat_arb_gnt", wr_gnt, 0);
        @(negedge clk);
        check("lat_aw_awvalid", s_awvalid, 1);
        check("lat_aw_addr", s_awaddr, 0);
        check("lat_aw_gnt", wr_gnt, 2'b01);
      end
    join
    check("single_gnt_idle", wr_gnt, 0);

    // m1 read overlapping an m0 write
    push_write(0, 2'd3, 32'h55667788);
    push_read(1, 2'd2);
    fork
      do_write(0, 2'd3, 32'h55667788);
      do_read(1, 2'd2);
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (rd_gnt != 2'b00 && wr_gnt != 2'b00) break;
        end
        check("overlap_rd_gnt", rd_gnt, 2'b10);
        check("overlap_wr_gnt", wr_gnt, 2'b01);
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (s_wvalid && s_rvalid) break;
        end
        check("overlap_w_and_r", {s_wvalid, s_rvalid}, 2'b11);
      end
    join
    check("overlap_rd_idle", rd_gnt, 0);

    // slave wready 1,0,0,1: beat 1 held stable while stalled
    sl_wready = 1'b0;
    push_write(0, 2'd2, 32'h99AABBCC);
    fork
      do_write(0, 2'd2, 32'h99AABBCC);
      begin
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (s_wvalid) break; end
        check("bp_wvalid_seen", s_wvalid, 1);
        @(posedge clk); #1; sl_wready = 1'b1;
        @(posedge clk); #1; sl_wready = 1'b0;
        @(negedge clk);
        check("bp_hold1_data", s_wdata, 8'hAA);
        check("bp_hold1_gnt", wr_gnt, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_hold2_data", s_wdata, 8'hAA);
        check("bp_hold2_valid", s_wvalid, 1);
        @(posedge clk); #1; sl_wready = 1'b1;
      end
    join

    // async reset during the third beat
    @(posedge clk); #1;
    q_aw.push_back('{0, 8'h01, 1'b0});
    q_w.push_back('{0, 8'h5A, 1'b0});
    q_w.push_back('{0, 8'h6B, 1'b0});
    tb_awaddr[0] = 2'd1;
    tb_awv[0]    = 1'b1;
    wait_awready(0);
    @(posedge clk); #1;
    tb_awv[0] = 1'b0;
    tb_wdata[0] = 8'h5A; tb_wv[0] = 1'b1;
    wait_wready(0);
    @(posedge clk); #1;
    tb_wdata[0] = 8'h6B;
    wait_wready(0);
    @(posedge clk); #1;
    tb_wdata[0] = 8'h7C;
    sl_wready   = 1'b0;
    @(negedge clk);
    check("rst_mid_beat2", s_wdata, 8'h7C);
    #1 _rst = 1'b0;
    #1 check_quiet("rst_mid");
    clear_masters();
    sl_wready = 1'b1;
    @(posedge clk); #1;
    _rst = 1'b1;
    @(posedge clk); #1;

    // first contest after reset goes to m0 again
    push_write(0, 2'd0, 32'hC1C2C3C4);
    push_write(1, 2'd3, 32'hD1D2D3D4);
    fork
      do_write(0, 2'd0, 32'hC1C2C3C4);
      do_write(1, 2'd3, 32'hD1D2D3D4);
      begin
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (wr_gnt != 2'b00) break; end
        check("post_rst_first_gnt", wr_gnt, 2'b01);
      end
    join

    // ten contested rounds alternate m0, m1, ...
    base0 = aw_cnt[0];
    base1 = aw_cnt[1];
    for (int r = 0; r < 5; r++) begin
      push_write(0, 2'(r), 32'h10203040 + 32'(r));
      push_write(1, 2'(r + 1), 32'hA0B0C0D0 + 32'(r));
    end
    fork
      begin for (int r = 0; r < 5; r++) do_write(0, 2'(r), 32'h10203040 + 32'(r)); end
      begin for (int r = 0; r < 5; r++) do_write(1, 2'(r + 1), 32'hA0B0C0D0 + 32'(r)); end
    join
    check("rounds_m0_count", aw_cnt[0] - base0, 5);
    check("rounds_m1_count", aw_cnt[1] - base1, 5);

    repeat (3) @(posedge clk);
    check("end_q_aw_empty", q_aw.size(), 0);
    check("end_q_w_empty",  q_w.size(),  0);
    check("end_q_b_empty",  q_b.size(),  0);
    check("end_q_ar_empty", q_ar.size(), 0);
    check("end_q_r_empty",  q_r.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
